// File: rtl/result_checker.sv
// result_checker: monitors CPU writes to TEST_PORT and compares each word against a
// preloaded expected-value table, reporting mismatch count, first failing index and
// run duration. Define CHECKER_TIMEOUT_EN to build in the no-progress watchdog.
module result_checker #(
   parameter int unsigned       ADDR_W    = 30,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 64,
   parameter logic [ADDR_W-1:0] TEST_PORT = 30'hFF,
   parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000168,
   parameter logic [DATA_W-1:0] END_SYM   = 32'hFFFFFD5D,
   parameter logic [15:0]       TIMEOUT   = 16'd4096,
   localparam int unsigned      IDX_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [IDX_W-1:0]  cfg_num,
   output logic [7:0]        error_num,
   output logic [15:0]       duration,
   output logic              finish,
   output logic              pass,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic              timeout
);

   localparam int unsigned      AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      NB        = DATA_W / 8;
   localparam logic [IDX_W-1:0] IDX_ONES  = '1;
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   logic [DATA_W-1:0] exp_mem [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [7:0]        err_q, err_d;
   logic [15:0]       dur_q, dur_d;
   logic              fin_q, fin_d;
   logic [IDX_W-1:0]  ferr_q, ferr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  num_q, num_d;
   logic              wen_prev_q;

   logic [DATA_W-1:0] data_be_c;
   logic [DATA_W-1:0] exp_c;
   logic [IDX_W-1:0]  cfg_eff_c;
   logic              hit_c;
   logic              last_c;
   logic              mism_c;

`ifdef CHECKER_TIMEOUT_EN
   logic [15:0]       wd_q, wd_d;
   logic              to_q, to_d;
`endif

   // CPU data arrives little-endian; the table holds readable byte order
   always_comb begin
      data_be_c = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         data_be_c[8*b +: 8] = data[DATA_W-8-8*b +: 8];
      end
   end

   // a hit is the rising edge of wen at the monitored address, so stalled writes count once
   assign hit_c     = wen && !wen_prev_q && (addr == TEST_PORT);
   assign cfg_eff_c = ((cfg_num == '0) || (cfg_num > DEPTH_IDX)) ? DEPTH_IDX : cfg_num;
   assign exp_c     = exp_mem[idx_q[AW-1:0]];
   assign last_c    = (idx_q == (num_q - IDX_W'(1)));
   assign mism_c    = (data_be_c != exp_c);

   // expected table is writable only while idle and is deliberately not reset
   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && ld_en && (ld_idx < DEPTH_IDX)) begin
         exp_mem[ld_idx[AW-1:0]] <= ld_data;
      end
   end

   // next-state and counter update
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      dur_d   = dur_q;
      fin_d   = fin_q;
      ferr_d  = ferr_q;
      idx_d   = idx_q;
      num_d   = num_q;
`ifdef CHECKER_TIMEOUT_EN
      wd_d    = wd_q;
      to_d    = to_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (hit_c && (data_be_c == BEGIN_SYM)) begin
               state_d = ST_CHECK;
               err_d   = '0;
               dur_d   = '0;
               ferr_d  = IDX_ONES;
               idx_d   = '0;
               num_d   = cfg_eff_c;
`ifdef CHECKER_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         ST_CHECK: begin
            if (dur_q != 16'hFFFF) begin
               dur_d = dur_q + 16'd1;
            end
            if (hit_c) begin
               idx_d = idx_q + IDX_W'(1);
               if (mism_c) begin
                  if (err_q != 8'hFF) begin
                     err_d = err_q + 8'd1;
                  end
                  if (err_q == 8'd0) begin
                     ferr_d = idx_q;
                  end
               end
               // an unexpected END marker is already a mismatch; it also ends the run early
               if (last_c || ((data_be_c == END_SYM) && (exp_c != END_SYM))) begin
                  state_d = ST_REPORT;
                  fin_d   = 1'b1;
               end
            end
`ifdef CHECKER_TIMEOUT_EN
            if (hit_c) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + 16'd1;
               if ((wd_q + 16'd1) >= TIMEOUT) begin
                  to_d    = 1'b1;
                  state_d = ST_REPORT;
                  fin_d   = 1'b1;
               end
            end
`endif
         end
         ST_REPORT: begin
            state_d = ST_REPORT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         err_q      <= 8'hFF;
         dur_q      <= '0;
         fin_q      <= 1'b0;
         ferr_q     <= IDX_ONES;
         idx_q      <= '0;
         num_q      <= DEPTH_IDX;
         wen_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         dur_q      <= dur_d;
         fin_q      <= fin_d;
         ferr_q     <= ferr_d;
         idx_q      <= idx_d;
         num_q      <= num_d;
         wen_prev_q <= wen;
      end
   end

`ifdef CHECKER_TIMEOUT_EN
   // watchdog: cycles in CHECK since entry or since the last hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         to_q <= to_d;
      end
   end
   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   assign error_num     = err_q;
   assign duration      = dur_q;
   assign finish        = fin_q;
   assign first_err_idx = ferr_q;
   assign pass          = fin_q && (err_q == 8'd0) && !timeout;

endmodule

// File: tb/tb_result_checker.sv
// Testbench for result_checker: directed scenarios plus randomized runs checked
// against a table-walking reference model. Honours CHECKER_TIMEOUT_EN.
module tb_result_checker;

   localparam logic [29:0] TP   = 30'hFF;
   localparam logic [31:0] BEG  = 32'h00000168;
   localparam logic [31:0] ENDS = 32'hFFFFFD5D;
`ifdef CHECKER_TIMEOUT_EN
   localparam logic [15:0] TO   = 16'd100;
`else
   localparam logic [15:0] TO   = 16'd4096;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic        wen = 1'b0;
   logic        ld_en = 1'b0;
   logic [6:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;
   logic [6:0]  cfg_num = 7'd43;
   logic [7:0]  error_num;
   logic [15:0] duration;
   logic        finish;
   logic        pass;
   logic [6:0]  first_err_idx;
   logic        timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int begin_edge = 0;
   bit noise_ld = 1'b0;
   logic [31:0] tbl [64];
   logic [31:0] sent [$];
   int hit_edges [$];

   result_checker #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .cfg_num(cfg_num),
      .error_num(error_num), .duration(duration), .finish(finish), .pass(pass),
      .first_err_idx(first_err_idx), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] swap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // walk the sent words against the table: errors, first bad index, words consumed
   function automatic void model(input int cfg, output int e, output int f, output int used);
      int n;
      n = (cfg == 0 || cfg > 64) ? 64 : cfg;
      e = 0; f = 127; used = 0;
      for (int i = 0; i < sent.size(); i++) begin
         used = i + 1;
         if (sent[i] != tbl[i]) begin
            if (e < 255) e++;
            if (f == 127) f = i;
         end
         if (i == n - 1) break;
         if (sent[i] == ENDS && tbl[i] != ENDS) break;
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wen = 1'b0; ld_en = 1'b0; rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   task automatic send(input logic [31:0] v, input int hold, input int gap);
      addr = TP; data = swap32(v); wen = 1'b1;
      hit_edges.push_back(cyc + 1);
      tick(hold);
      wen = 1'b0; addr = 30'($urandom) | 30'h100; data = $urandom;
      if (noise_ld) begin
         ld_en = 1'b1; ld_idx = 7'($urandom_range(0, 63)); ld_data = $urandom;
      end
      tick(gap);
      ld_en = 1'b0;
   endtask

   task automatic start_run(input int cfg, input bit with_ld);
      int j;
      logic [31:0] v;
      cfg_num = 7'(cfg);
      if (with_ld) begin
         j = $urandom_range(43, 63); v = $urandom;
         ld_en = 1'b1; ld_idx = 7'(j); ld_data = v; tbl[j] = v;
      end
      begin_edge = cyc + 1;
      addr = TP; data = swap32(BEG); wen = 1'b1;
      tick(1);
      wen = 1'b0; ld_en = 1'b0; addr = 30'h100;
      tick(1);
      cfg_num = 7'($urandom);
      hit_edges.delete();
   endtask

   task automatic load_table();
      logic [31:0] a, b, t;
      a = 32'd1; b = 32'd1;
      for (int i = 0; i < 21; i++) begin
         tbl[i] = a; t = a + b; a = b; b = t;
      end
      for (int i = 21; i < 42; i++) tbl[i] = tbl[41 - i];
      tbl[42] = ENDS;
      for (int i = 43; i < 64; i++) tbl[i] = $urandom;
      for (int i = 0; i < 64; i++) begin
         ld_en = 1'b1; ld_idx = 7'(i); ld_data = tbl[i];
         tick(1);
      end
      for (int i = 0; i < 4; i++) begin
         ld_idx = 7'(64 + $urandom_range(0, 63)); ld_data = $urandom;
         tick(1);
      end
      ld_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (error_num !== 8'hFF) begin errors++; $display("FAIL reset_err got %h want ff", error_num); end
      checks++; if (duration !== 16'd0) begin errors++; $display("FAIL reset_dur got %0d want 0", duration); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
      checks++; if (first_err_idx !== 7'h7F) begin errors++; $display("FAIL reset_first got %h want 7f", first_err_idx); end
   endtask

   task automatic test_pass();
      int d;
      do_reset();
      sent.delete();
      for (int i = 0; i < 43; i++) sent.push_back(tbl[i]);
      start_run(43, 1'b0);
      for (int i = 0; i < 42; i++) send(sent[i], 1, $urandom_range(1, 3));
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL pass_early_finish got %b want 0", finish); end
      send(sent[42], 1, 2);
      d = hit_edges[42] - begin_edge;
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL pass_finish got %b want 1", finish); end
      checks++; if (error_num !== 8'd0) begin errors++; $display("FAIL pass_err got %0d want 0", error_num); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got %b want 1", pass); end
      checks++; if (first_err_idx !== 7'h7F) begin errors++; $display("FAIL pass_first got %h want 7f", first_err_idx); end
      checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL pass_dur got %0d want %0d", duration, d); end
   endtask

   task automatic test_corrupt();
      do_reset();
      sent.delete();
      for (int i = 0; i < 43; i++) sent.push_back(tbl[i]);
      sent[5] = tbl[5] ^ 32'h0000_1000;
      sent[9] = tbl[9] ^ 32'h8000_0001;
      start_run(43, 1'b0);
      for (int i = 0; i < 43; i++) send(sent[i], 1, 1);
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL corrupt_finish got %b want 1", finish); end
      checks++; if (error_num !== 8'd2) begin errors++; $display("FAIL corrupt_err got %0d want 2", error_num); end
      checks++; if (first_err_idx !== 7'd5) begin errors++; $display("FAIL corrupt_first got %0d want 5", first_err_idx); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass got %b want 0", pass); end
   endtask

   task automatic test_stall();
      int d;
      do_reset();
      sent.delete();
      for (int i = 0; i < 43; i++) sent.push_back(tbl[i]);
      start_run(43, 1'b0);
      for (int i = 0; i < 42; i++) send(sent[i], (i % 5 == 2) ? 3 : $urandom_range(1, 3), 1);
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL stall_early_finish got %b want 0", finish); end
      checks++; if (error_num !== 8'd0) begin errors++; $display("FAIL stall_mid_err got %0d want 0", error_num); end
      send(sent[42], 3, 1);
      d = hit_edges[42] - begin_edge;
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL stall_finish got %b want 1", finish); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL stall_pass got %b want 1", pass); end
      checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL stall_dur got %0d want %0d", duration, d); end
   endtask

   task automatic test_early_end();
      int d;
      do_reset();
      start_run(43, 1'b0);
      for (int i = 0; i < 10; i++) send(tbl[i], 1, 1);
      send(ENDS, 1, 1);
      d = hit_edges[10] - begin_edge;
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL early_finish got %b want 1", finish); end
      checks++; if (error_num !== 8'd1) begin errors++; $display("FAIL early_err got %0d want 1", error_num); end
      checks++; if (first_err_idx !== 7'd10) begin errors++; $display("FAIL early_first got %0d want 10", first_err_idx); end
      checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL early_dur got %0d want %0d", duration, d); end
      for (int i = 0; i < 5; i++) send(~tbl[11 + i], 1, 2);
      checks++; if (error_num !== 8'd1) begin errors++; $display("FAIL frozen_err got %0d want 1", error_num); end
      checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL frozen_dur got %0d want %0d", duration, d); end
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL frozen_finish got %b want 1", finish); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_run(43, 1'b0);
      for (int i = 0; i < 20; i++) send(tbl[i], 1, 1);
      wen = 1'b0; rst = 1'b0;
      #1;
      checks++; if (error_num !== 8'hFF) begin errors++; $display("FAIL midrst_err got %h want ff", error_num); end
      checks++; if (duration !== 16'd0) begin errors++; $display("FAIL midrst_dur got %0d want 0", duration); end
      checks++; if (first_err_idx !== 7'h7F) begin errors++; $display("FAIL midrst_first got %h want 7f", first_err_idx); end
      tick(2);
      rst = 1'b1;
      tick(1);
      send(tbl[0], 1, 1);
      send(tbl[1], 1, 1);
      checks++; if (error_num !== 8'hFF) begin errors++; $display("FAIL idle_ignore_err got %h want ff", error_num); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL idle_ignore_finish got %b want 0", finish); end
      start_run(43, 1'b0);
      for (int i = 0; i < 43; i++) send(tbl[i], 1, 1);
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got %b want 1", pass); end
      checks++; if (error_num !== 8'd0) begin errors++; $display("FAIL rerun_err got %0d want 0", error_num); end
   endtask

`ifdef CHECKER_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      start_run(43, 1'b0);
      tick(98);
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL to_early_finish got %b want 0", finish); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early_timeout got %b want 0", timeout); end
      tick(1);
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_timeout got %b want 1", timeout); end
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL to_finish got %b want 1", finish); end
      checks++; if (duration !== 16'd100) begin errors++; $display("FAIL to_dur got %0d want 100", duration); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass got %b want 0", pass); end
   endtask
`else
   task automatic test_timeout();
      int d;
      do_reset();
      start_run(43, 1'b0);
      tick(4998);
      d = cyc - begin_edge;
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL nowd_timeout got %b want 0", timeout); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL nowd_finish got %b want 0", finish); end
      checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL nowd_dur got %0d want %0d", duration, d); end
   endtask
`endif

   task automatic test_random();
      int cfg, n, e, f, u, d, r, pick;
      for (int it = 0; it < 10; it++) begin
         do_reset();
         for (int k = 0; k < 3; k++) begin
            r = $urandom_range(43, 63); tbl[r] = $urandom;
            ld_en = 1'b1; ld_idx = 7'(r); ld_data = tbl[r];
            tick(1);
         end
         ld_en = 1'b0;
         pick = $urandom_range(0, 5);
         cfg = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(65, 127) : $urandom_range(1, 64);
         n = (cfg == 0 || cfg > 64) ? 64 : cfg;
         sent.delete();
         for (int i = 0; i < n + 2; i++) begin
            r = $urandom_range(0, 99);
            if (i >= 64) sent.push_back($urandom);
            else if (r < 80) sent.push_back(tbl[i]);
            else if (r < 92) sent.push_back(tbl[i] ^ (32'($urandom) | 32'd1));
            else sent.push_back(ENDS);
         end
         start_run(cfg, 1'($urandom_range(0, 1)));
         noise_ld = 1'b1;
         for (int i = 0; i < sent.size(); i++) send(sent[i], $urandom_range(1, 3), $urandom_range(1, 3));
         noise_ld = 1'b0;
         model(cfg, e, f, u);
         d = hit_edges[u - 1] - begin_edge;
         checks++; if (finish !== 1'b1) begin errors++; $display("FAIL rnd%0d_finish got %b want 1", it, finish); end
         checks++; if (error_num !== 8'(e)) begin errors++; $display("FAIL rnd%0d_err got %0d want %0d", it, error_num, e); end
         checks++; if (first_err_idx !== 7'(f)) begin errors++; $display("FAIL rnd%0d_first got %0d want %0d", it, first_err_idx, f); end
         checks++; if (pass !== (e == 0)) begin errors++; $display("FAIL rnd%0d_pass got %b want %b", it, pass, (e == 0)); end
         checks++; if (duration !== 16'(d)) begin errors++; $display("FAIL rnd%0d_dur got %0d want %0d", it, duration, d); end
      end
   endtask

   initial begin
      test_reset();
      load_table();
      test_pass();
      test_corrupt();
      test_stall();
      test_early_end();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL provide parameter ADDR_W, default 30, meaning width of the word address bus.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning width of the data bus, which is a multiple of 8.
REQ-003 SHALL provide parameter DEPTH, default 64, meaning the number of expected-value entries; IDX_W = clog2(DEPTH+1).
REQ-004 SHALL provide parameter TEST_PORT, default 30'hFF, meaning the monitored word address.
REQ-005 SHALL provide parameter BEGIN_SYM, default 32'h00000168, meaning the start marker.
REQ-006 SHALL provide parameter END_SYM, default 32'hFFFFFD5D, meaning the end marker.
REQ-007 SHALL provide parameter TIMEOUT, default 16'd4096, meaning the watchdog limit in cycles.
REQ-008 SHALL have port clk, input, 1 bit, system clock.
REQ-009 SHALL have port rst, input, 1 bit, reset; reset is rst, asynchronous, active-low; the clock is clk.
REQ-010 SHALL have the following ports:
- addr: input, ADDR_W, CPU data-memory word address.
- data: input, DATA_W, CPU write data, little-endian.
- wen: input, 1 bit, CPU write enable.
- ld_en: input, 1 bit, expected-table write strobe.
- ld_idx: input, IDX_W, table index.
- ld_data: input, DATA_W, expected value in readable byte order.
- cfg_num: input, IDX_W, number of checks per run, range 1..DEPTH.
REQ-011 SHALL have the following status output ports:
- error_num: output, 8 bits, mismatch count.
- duration: output, 16 bits, cycles in CHECK.
- finish: output, 1 bit, run complete.
- pass: output, 1 bit, run clean.
- first_err_idx: output, IDX_W, index of the first mismatch.
- timeout: output, 1 bit, watchdog fired.

Function
REQ-012 SHALL byte-reverse data, giving data_be, before every comparison.
REQ-013 SHALL count a write as a hit only when addr==TEST_PORT, wen=1, and wen was 0 in the previous cycle, so that a write held across a stall counts once.
REQ-014 SHALL implement FSM states IDLE, CHECK and REPORT; the reset state is IDLE.
REQ-015 In IDLE, a hit with data_be==BEGIN_SYM SHALL cause a move to CHECK next cycle, with error_num=0, idx=0, duration=0 and first_err_idx=all-ones; other hits SHALL be ignored.
REQ-016 In IDLE, ld_en SHALL write exp_mem[ld_idx]=ld_data when ld_idx<DEPTH; ld_en SHALL be ignored in CHECK and REPORT.
REQ-017 In CHECK, duration SHALL increment every cycle, saturating at 16'hFFFF.
REQ-018 In CHECK, each hit SHALL compare data_be against exp_mem[idx]; on mismatch, error_num SHALL increment, saturating at 255; idx SHALL increment on every hit.
REQ-019 On the first mismatch of a run, first_err_idx SHALL capture idx; later mismatches SHALL leave it unchanged.
REQ-020 A hit with idx==cfg_num-1 SHALL be checked and then cause a move to REPORT next cycle.
REQ-021 A hit with data_be==END_SYM and idx<cfg_num-1, where exp_mem[idx]!=END_SYM, SHALL count as one error and move to REPORT (early termination).
REQ-022 In REPORT, finish=1, all counters SHALL freeze, hits SHALL be ignored, and the block SHALL remain in REPORT until reset.
REQ-023 pass SHALL equal finish AND error_num==0 AND timeout==0, combinationally.
REQ-024 A cfg_num value of 0 or greater than DEPTH SHALL be treated as DEPTH, latched on entry to CHECK.
REQ-025 When ld_en and a BEGIN hit occur in the same IDLE cycle, the load SHALL complete and the transition SHALL occur.

Reset
REQ-026 Reset SHALL set the state to IDLE, error_num=8'hFF, duration=0, finish=0, timeout=0, first_err_idx=all-ones, idx=0 and the previous-wen flag to 0.
REQ-027 exp_mem SHALL NOT be reset; its contents SHALL survive rst.
REQ-028 Reset asserted mid-CHECK SHALL abort the run immediately; a new BEGIN_SYM is required to restart.

Configuration
REQ-029 With CHECKER_TIMEOUT_EN defined, a watchdog SHALL count CHECK cycles since the last hit, or since entry to CHECK; on reaching TIMEOUT, the block SHALL set timeout=1 and move to REPORT.
REQ-030 Without CHECKER_TIMEOUT_EN, the watchdog logic SHALL be absent and timeout SHALL be tied to 0.

Verification
REQ-031 Load the Fibonacci-up/down table of 43 entries with entry 42=END_SYM, set cfg_num=43, and issue BEGIN followed by 43 correct writes -> finish=1, error_num=0, pass=1.
REQ-032 Same run with entries 5 and 9 corrupted -> error_num=2, first_err_idx=5, pass=0.
REQ-033 Hold wen high for 3 cycles on one write during CHECK -> idx advances by 1 only.
REQ-034 Send END_SYM at idx=10 with cfg_num=43 -> REPORT, error_num=1.
REQ-035 With CHECKER_TIMEOUT_EN and TIMEOUT=100, send BEGIN and then no writes -> timeout=1 and finish=1 after 100 cycles, with duration=100.
REQ-036 Assert rst at idx=20, then rerun -> error_num=8'hFF during IDLE, exp_mem intact, and the second run passes.
